// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: request/response bus for both ports plus the memory-side
// strobes of imem_arbiter. The arbiter connects through the slave modport; the
// requesters and the memory sit on the master side.
interface imem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_gnt;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_rvalid;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wn;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
        output p0_gnt, p0_rdata, p0_rvalid, p1_gnt, p1_rdata, p1_rvalid,
               mem_addr, mem_wdata, mem_wn, mem_rd, busy
    );

    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
        input  p0_gnt, p0_rdata, p0_rvalid, p1_gnt, p1_rdata, p1_rvalid,
               mem_addr, mem_wdata, mem_wn, mem_rd, busy
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port arbiter and access sequencer for the instruction
// memory. Port 0 fetches (read-only); port 1 loads/debugs (read/write).
// One access at a time: ISSUE drives the strobes for one cycle, WAIT covers
// the memory read latency, RESP pulses rvalid and re-arbitrates.
// Build option: define IMEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 1 has fixed priority over port 0.
module imem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);
    localparam logic [2:0] LAT_C = 3'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              cur_port_q, cur_port_d;
    logic              cur_we_q, cur_we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
    logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wn_q, mem_wn_d, mem_rd_q, mem_rd_d;
    logic              busy_q, busy_d;
    logic              any_req_s, win_port_s, sel_port_s, grant_s;

    assign any_req_s = bus.p0_req | bus.p1_req;

`ifdef IMEM_ARB_RR_EN
    logic last_q, last_d;

    // Round-robin pick: on a tie the port not served last wins
    always_comb begin
        if (bus.p0_req && bus.p1_req) begin
            win_port_s = ~last_q;
        end else if (bus.p1_req) begin
            win_port_s = 1'b1;
        end else begin
            win_port_s = 1'b0;
        end
    end
`else
    // Fixed priority pick: the loader port always beats the fetch port
    always_comb begin
        if (bus.p1_req) begin
            win_port_s = 1'b1;
        end else begin
            win_port_s = 1'b0;
        end
    end
`endif

    // Next state, latched request fields and next values of all outputs
    always_comb begin
        state_d     = state_q;
        cur_port_d  = cur_port_q;
        cur_we_d    = cur_we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_gnt_d    = 1'b0;
        p1_gnt_d    = 1'b0;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        mem_wn_d    = 1'b0;
        mem_rd_d    = 1'b0;
        grant_s     = 1'b0;
        sel_port_s  = win_port_s;
`ifdef IMEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                grant_s = any_req_s;
            end
            S_ISSUE: begin
                if (cur_we_q) begin
                    // The port being granted still holds req this cycle; that
                    // request is the one being served, so only the other port
                    // can be a pending request for a back-to-back grant.
                    state_d    = S_IDLE;
                    sel_port_s = ~cur_port_q;
                    if (cur_port_q) begin
                        grant_s = bus.p0_req;
                    end else begin
                        grant_s = bus.p1_req;
                    end
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_C;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    if (cur_port_q) begin
                        p1_rdata_d  = bus.mem_rdata;
                        p1_rvalid_d = 1'b1;
                    end else begin
                        p0_rdata_d  = bus.mem_rdata;
                        p0_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_s) begin
            state_d    = S_ISSUE;
            cur_port_d = sel_port_s;
            if (sel_port_s) begin
                cur_we_d    = bus.p1_we;
                mem_addr_d  = bus.p1_addr;
                mem_wdata_d = bus.p1_wdata;
                p1_gnt_d    = 1'b1;
                mem_wn_d    = bus.p1_we;
                mem_rd_d    = ~bus.p1_we;
            end else begin
                cur_we_d   = 1'b0;
                mem_addr_d = bus.p0_addr;
                p0_gnt_d   = 1'b1;
                mem_rd_d   = 1'b1;
            end
`ifdef IMEM_ARB_RR_EN
            last_d = sel_port_s;
`endif
        end else begin
            cur_port_d = cur_port_q;
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    end

    // State and output registers; reset clears everything and drops any pending read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_port_q  <= 1'b0;
            cur_we_q    <= 1'b0;
            cnt_q       <= 3'd0;
            p0_gnt_q    <= 1'b0;
            p1_gnt_q    <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= {DATA_W{1'b0}};
            p1_rdata_q  <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_wn_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef IMEM_ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_port_q  <= cur_port_d;
            cur_we_q    <= cur_we_d;
            cnt_q       <= cnt_d;
            p0_gnt_q    <= p0_gnt_d;
            p1_gnt_q    <= p1_gnt_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wn_q    <= mem_wn_d;
            mem_rd_q    <= mem_rd_d;
            busy_q      <= busy_d;
`ifdef IMEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.p0_gnt    = p0_gnt_q;
    assign bus.p1_gnt    = p1_gnt_q;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wn    = mem_wn_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter. Two instances
// (RD_LAT=1 and RD_LAT=3) each with a small behavioural memory. Expected
// values come from a transaction-level model: service order from the
// arbitration rule, grant/response cycles from the latency arithmetic, and
// read data from a shadow copy of memory.
module tb_imem_arbiter;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
    imem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b3 ();

    imem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    imem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Memories: synchronous write, read data appears RD_LAT edges after mem_rd
    logic [31:0] m1 [16];
    logic [31:0] m3 [16];
    logic [31:0] q1;
    logic [31:0] q3 [1:3];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                m1[i] <= 32'h0;
                m3[i] <= 32'h0;
            end
        end else begin
            if (b1.mem_wn) m1[b1.mem_addr[3:0]] <= b1.mem_wdata;
            if (b3.mem_wn) m3[b3.mem_addr[3:0]] <= b3.mem_wdata;
        end
        q1    <= b1.mem_rd ? m1[b1.mem_addr[3:0]] : 32'hDEAD_BEEF;
        q3[1] <= b3.mem_rd ? m3[b3.mem_addr[3:0]] : 32'hDEAD_BEEF;
        q3[2] <= q3[1];
        q3[3] <= q3[2];
    end
    assign b1.mem_rdata = q1;
    assign b3.mem_rdata = q3[3];

    int checks = 0;
    int errors = 0;
    logic [31:0] sh [16];
    bit rr_m;
    bit last_m;

    typedef struct {
        bit          r0;
        logic [15:0] a0;
        bit          r1;
        bit          w1;
        logic [15:0] a1;
        logic [31:0] d1;
        int          exp_port;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction round on the RD_LAT=1 instance, requests raised together in cycle 0
    task automatic run_round(input bit r0, input logic [15:0] a0, input bit r1, input bit w1,
                             input logic [15:0] a1, input logic [31:0] d1,
                             output int first_port, output logic [31:0] rd0, output logic [31:0] rd1);
        int gc [2];
        int rc [2];
        logic [31:0] ed [2];
        int order [2];
        int n;
        int p;
        int hi;
        bit drop0, drop1;
        bit e_g0, e_g1, e_rv0, e_rv1, e_rd, e_wn, e_busy;
        gc = '{-1, -1};
        rc = '{-1, -1};
        ed = '{32'h0, 32'h0};
        order = '{0, 0};
        n = 0;
        if (r0 && r1) begin
            order[0] = rr_m ? (last_m ? 0 : 1) : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else if (r1) begin
            order[0] = 1;
            n = 1;
        end else if (r0) begin
            order[0] = 0;
            n = 1;
        end
        for (int i = 0; i < n; i++) begin
            p = order[i];
            if (i == 0) gc[p] = 1;
            else if (order[0] == 1 && w1) gc[p] = gc[order[0]] + 1;
            else gc[p] = gc[order[0]] + 2 + LAT1;
            if (p == 1 && w1) begin
                sh[a1[3:0]] = d1;
            end else begin
                rc[p] = gc[p] + 1 + LAT1;
                ed[p] = (p == 1) ? sh[a1[3:0]] : sh[a0[3:0]];
            end
            last_m = (p == 1);
        end
        first_port = (n > 0) ? order[0] : -1;

        b1.p0_req = r0; b1.p0_addr = a0;
        b1.p1_req = r1; b1.p1_we = w1; b1.p1_addr = a1; b1.p1_wdata = d1;
        drop0 = 1'b0; drop1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (drop0) b1.p0_req = 1'b0;
            if (drop1) b1.p1_req = 1'b0;
            e_g0 = (c == gc[0]); e_g1 = (c == gc[1]);
            e_rv0 = (c == rc[0]); e_rv1 = (c == rc[1]);
            e_rd = e_g0 || (e_g1 && !w1);
            e_wn = e_g1 && w1;
            e_busy = 1'b0;
            for (int q = 0; q < 2; q++) begin
                if (gc[q] > 0) begin
                    hi = gc[q] + ((q == 1 && w1) ? 0 : LAT1);
                    if (c >= gc[q] && c <= hi) e_busy = 1'b1;
                end
            end
            chk("round_ctl", 32'({b1.p0_gnt, b1.p1_gnt, b1.p0_rvalid, b1.p1_rvalid, b1.mem_rd, b1.mem_wn, b1.busy}),
                32'({e_g0, e_g1, e_rv0, e_rv1, e_rd, e_wn, e_busy}));
            if (e_g0) chk("round_addr0", 32'(b1.mem_addr), 32'(a0));
            if (e_g1) chk("round_addr1", 32'(b1.mem_addr), 32'(a1));
            if (e_g1 && w1) chk("round_wdata", b1.mem_wdata, d1);
            if (e_rv0) chk("round_rdata0", b1.p0_rdata, ed[0]);
            if (e_rv1) chk("round_rdata1", b1.p1_rdata, ed[1]);
            drop0 = b1.p0_gnt; drop1 = b1.p1_gnt;
        end
        b1.p0_req = 1'b0; b1.p1_req = 1'b0;
        rd0 = b1.p0_rdata; rd1 = b1.p1_rdata;
    endtask

    initial begin
        int fp;
        logic [31:0] rd0, rd1;
        bit prev_g, e_g, e_rv, e0, e1, on;
        int idx, k;
        bit r0, r1, w1;

        rr_m = 1'b0;
`ifdef IMEM_ARB_RR_EN
        rr_m = 1'b1;
`endif
        last_m = 1'b0;
        for (int i = 0; i < 16; i++) sh[i] = 32'h0;
        b1.p0_req = 1'b0; b1.p0_addr = 16'h0; b1.p1_req = 1'b0; b1.p1_we = 1'b0;
        b1.p1_addr = 16'h0; b1.p1_wdata = 32'h0;
        b3.p0_req = 1'b0; b3.p0_addr = 16'h0; b3.p1_req = 1'b0; b3.p1_we = 1'b0;
        b3.p1_addr = 16'h0; b3.p1_wdata = 32'h0;
        rst = 1'b1; clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({b1.p0_gnt, b1.p1_gnt, b1.p0_rvalid, b1.p1_rvalid, b1.mem_rd, b1.mem_wn, b1.busy, b3.busy}), 32'h0);
        chk("reset_data", b1.p0_rdata | b1.p1_rdata | b1.mem_wdata, 32'h0);
        chk("reset_addr", 32'(b1.mem_addr), 32'h0);
        clr = 1'b0; rst = 1'b0;
        tick();

        // Single-transaction vectors: writes, then read-back through both ports
        tbl[0] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h4, 32'h12, 1, 32'h0};
        tbl[1] = '{1'b1, 16'h4, 1'b0, 1'b0, 16'h0, 32'h0,  0, 32'h12};
        tbl[2] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0, 32'h0,  1, 32'h0};
        tbl[3] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h1, 32'h1,  1, 32'h0};
        tbl[4] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h2, 32'h10, 1, 32'h0};
        tbl[5] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h3, 32'h6,  1, 32'h0};
        tbl[6] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h2, 32'h0,  1, 32'h10};
        tbl[7] = '{1'b1, 16'h3, 1'b0, 1'b0, 16'h0, 32'h0,  0, 32'h6};
        for (int i = 0; i < 8; i++) begin
            run_round(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, fp, rd0, rd1);
            chk("vec_port", 32'(fp), 32'(tbl[i].exp_port));
            if (!tbl[i].w1) chk("vec_rdata", (tbl[i].exp_port == 1) ? rd1 : rd0, tbl[i].exp_rd);
        end

        // Back-to-back fetch reads of 0..3: one response every 2+RD_LAT cycles
        b1.p0_req = 1'b1; b1.p0_addr = 16'h0; idx = 0; prev_g = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (prev_g) begin
                idx++;
                if (idx < 4) b1.p0_addr = 16'(idx);
                else b1.p0_req = 1'b0;
            end
            e_g = (c <= 10) && ((c - 1) % (2 + LAT1) == 0);
            e_rv = (c >= 3) && (c <= 12) && ((c - 3) % (2 + LAT1) == 0);
            chk("b2b_gnt", 32'(b1.p0_gnt), 32'(e_g));
            chk("b2b_rvalid", 32'(b1.p0_rvalid), 32'(e_rv));
            if (e_rv) chk("b2b_data", b1.p0_rdata, sh[(c - 3) / (2 + LAT1)]);
            prev_g = b1.p0_gnt;
        end
        last_m = 1'b0;

        // Reset during WAIT of a fetch read of 0x0002
        b1.p0_req = 1'b1; b1.p0_addr = 16'h2;
        tick();
        chk("rst_mid_gnt", 32'(b1.p0_gnt), 32'h1);
        tick();
        b1.p0_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 32'({b1.p0_gnt, b1.p1_gnt, b1.p0_rvalid, b1.p1_rvalid, b1.mem_rd, b1.mem_wn, b1.busy}), 32'h0);
        chk("rst_mid_data", b1.p0_rdata | b1.p1_rdata | b1.mem_wdata, 32'h0);
        chk("rst_mid_addr", 32'(b1.mem_addr), 32'h0);
        tick();
        rst = 1'b0;
        last_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rst_no_rvalid", 32'({b1.p0_rvalid, b1.p0_gnt, b1.busy}), 32'h0);
        end
        run_round(1'b1, 16'h2, 1'b0, 1'b0, 16'h0, 32'h0, fp, rd0, rd1);
        chk("rst_after_rdata", rd0, 32'h10);

        // Both ports reading continuously from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b1.p0_req = 1'b1; b1.p0_addr = 16'h5; b1.p1_req = 1'b1; b1.p1_we = 1'b0; b1.p1_addr = 16'h6;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 11) b1.p1_req = 1'b0;
            if (c == 14) b1.p0_req = 1'b0;
            on = (c <= 10) && ((c - 1) % (2 + LAT1) == 0);
            k = (c - 1) / (2 + LAT1);
            e1 = on && (rr_m ? (k % 2 == 0) : 1'b1);
            e0 = (on && !e1) || (c == 13);
            chk("arb_gnt", 32'({b1.p0_gnt, b1.p1_gnt}), 32'({e0, e1}));
        end
        last_m = 1'b0;

        // Randomized rounds against the transaction model
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            run_round(r0, 16'($urandom_range(0, 7)), r1, w1, 16'($urandom_range(0, 7)), $urandom, fp, rd0, rd1);
        end

        // RD_LAT=3: write 0x6 to 0x0003, then fetch it back
        b3.p1_req = 1'b1; b3.p1_we = 1'b1; b3.p1_addr = 16'h3; b3.p1_wdata = 32'h6;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) b3.p1_req = 1'b0;
            chk("lat3_wr", 32'({b3.p1_gnt, b3.mem_wn, b3.mem_rd}), (c == 1) ? 32'h6 : 32'h0);
            if (c == 1) chk("lat3_wr_addr", 32'(b3.mem_addr), 32'h3);
        end
        b3.p0_req = 1'b1; b3.p0_addr = 16'h3;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 2) b3.p0_req = 1'b0;
            chk("lat3_ctl", 32'({b3.p0_gnt, b3.busy, b3.p0_rvalid}),
                32'({c == 1, (c >= 1) && (c <= 4), c == 5}));
            if (c == 5) chk("lat3_data", b3.p0_rdata, 32'h6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and access sequencer for the shared InstructionMemory block (synchronous-write, synchronous-read, 16-bit address, 32-bit data). Port 0 is the CPU instruction-fetch port (read-only); port 1 is the program-loader/debug port (read/write). The arbiter accepts one request at a time, drives the memory strobes for exactly one cycle per access, waits the memory read latency, and returns read data with a one-cycle valid pulse to the winning port.

## Interface
- ADDR_W, 16, address width passed unmodified to memory
- DATA_W, 32, data width
- RD_LAT, 1, cycles from the edge that samples mem_rd to valid mem_rdata; legal range 1..7
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  fetch read request; hold until p0_gnt
- p0_addr  in  ADDR_W  fetch address; stable while p0_req high
- p0_gnt  out  1  one-cycle pulse: request accepted, access issued this cycle
- p0_rdata  out  DATA_W  read data; held until the next port-0 response
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid
- p1_req  in  1  loader request; hold until p1_gnt
- p1_we  in  1  1 = write, 0 = read; stable while p1_req high
- p1_addr  in  ADDR_W  loader address
- p1_wdata  in  DATA_W  loader write data
- p1_gnt, p1_rdata, p1_rvalid  out  1/DATA_W/1  as for port 0; no rvalid for writes
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write_data
- mem_wn  out  1  to memory wn (write strobe)
- mem_rd  out  1  to memory rd (read strobe)
- mem_rdata  in  DATA_W  from memory read_data
- busy  out  1  high in ISSUE and WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset → IDLE.
- IDLE/RESP: if any req is high at the edge, latch the winner (port, we, addr, wdata) and go to ISSUE; otherwise go to IDLE.
- ISSUE: pX_gnt=1; mem_addr/mem_wdata = latched values; mem_wn=1 for write, mem_rd=1 for read, never both. Write → IDLE (or straight to ISSUE if a request is pending, no bubble). Read → WAIT with counter loaded to RD_LAT.
- WAIT: counter decrements each cycle; when 1, capture mem_rdata into the winner's rdata register at that edge and go to RESP.
- RESP: winner's rvalid=1 for exactly this cycle; arbitration proceeds as in IDLE.
- Port 0 never issues writes; p1_we is ignored unless port 1 wins.
- Round-robin pointer `last` (0 after reset) updates on every grant; with both requests high, the port ≠ `last` wins.
- Requests deasserted before grant are dropped silently; no access occurs.
- Outputs registered. mem_addr/mem_wdata hold their last value outside ISSUE; strobes are 0 outside ISSUE.
- Reset mid-access: all outputs go to 0 immediately (async), pending read is discarded, no rvalid is emitted after release.

## Timing
- Reset values: every output 0; state IDLE; `last`=0.
- Read: req sampled high at end of cycle 0 → gnt + mem_rd in cycle 1 → rvalid in cycle 2+RD_LAT (cycle 3 for RD_LAT=1).
- Write: req sampled at end of cycle 0 → gnt + mem_wn in cycle 1; next grant possible in cycle 2.
- Read throughput: one read per 2+RD_LAT cycles; RESP overlaps the next arbitration.
- Requester may change fields in the cycle after gnt.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin arbitration as above.
- Not defined: fixed priority, port 1 always beats port 0; `last` pointer is not implemented; port 0 may starve while p1_req is held.

## Test plan
- rst pulsed during WAIT of a port-0 read of 0x0002 → all outputs 0 during reset; no p0_rvalid after release; next request is served normally.
- p1 write 0x00000012 to 0x0004 (RD_LAT=1) → cycle 1 mem_wn=1, mem_addr=0x0004, mem_wdata=0x12, p1_gnt=1; then p0 read 0x0004 → p0_rvalid in cycle 3 with p0_rdata=0x12.
- Load 0x0,0x1,0x10,0x6 to addresses 0..3 via p1, then p0 reads 0..3 back-to-back → rvalid every 3 cycles, data 0x0,0x1,0x10,0x6 in order.
- IMEM_ARB_RR_EN, both ports reading continuously after reset → grants p1,p0,p1,p0 (`last`=0 initially), never the same port twice in a row.
- Without IMEM_ARB_RR_EN, both requesting for 4 accesses → p1 granted 4 times, p0_gnt stays 0 until p1_req drops.
- RD_LAT=3, p0 read 0x0003 holding 0x6 → gnt cycle 1, p0_rvalid cycle 5 with 0x6; busy high cycles 1–4.
